// File: rtl/pipeline_ctrl.sv
// Pipeline hazard controller: memory freeze, branch flush,
// load-use stall, access timeout and event counters.
module pipeline_ctrl #(
  parameter int WAIT_LIMIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rt,
  input  logic        ex_memread,
  input  logic [4:0]  ex_rt,
  input  logic        ex_branch_taken,
  input  logic        mem_req,
  input  logic        mem_ready,
  input  logic        counters_clr,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        id_ex_write,
  output logic        ex_mem_write,
  output logic        mem_wb_write,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        bus_err,
  output logic [15:0] stall_cycles,
  output logic [15:0] flush_count
);

  typedef enum logic {
    RUN,
    MEM_WAIT
  } state_t;

  localparam logic [7:0] LAST = 8'(WAIT_LIMIT - 1);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] wait_cnt;
  logic [7:0] wait_cnt_nxt;
  logic       hazard;
  logic       freeze;
  logic       timeout;
  logic       br_flush;
  logic       ld_stall;

  assign hazard = ex_memread && (ex_rt != 5'd0) &&
                  ((ex_rt == id_rs) ||
                   (id_uses_rt && (ex_rt == id_rt)));

  assign br_flush = !freeze && ex_branch_taken;
  assign ld_stall = !freeze && !ex_branch_taken && hazard;

  // State and wait counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= RUN;
      wait_cnt <= 8'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // Next state, freeze and timeout decode
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    freeze       = 1'b0;
    timeout      = 1'b0;
    unique case (state)
      RUN: begin
        if (mem_req && !mem_ready) begin
          freeze       = 1'b1;
          state_nxt    = MEM_WAIT;
          wait_cnt_nxt = 8'd0;
        end
      end
      MEM_WAIT: begin
        if (mem_ready) begin
          state_nxt = RUN;
        end else if (wait_cnt < LAST) begin
          freeze       = 1'b1;
          wait_cnt_nxt = wait_cnt + 8'd1;
        end else begin
          timeout   = 1'b1;
          state_nxt = RUN;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  // Stage enables and flushes, one condition per cycle
  always_comb begin
    pc_write     = 1'b0;
    if_id_write  = 1'b0;
    id_ex_write  = 1'b0;
    ex_mem_write = 1'b0;
    mem_wb_write = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    bus_err      = 1'b0;
    if (!reset) begin
      bus_err = timeout;
      unique case (1'b1)
        freeze: begin
        end
        br_flush: begin
          pc_write     = 1'b1;
          if_id_write  = 1'b1;
          id_ex_write  = 1'b1;
          ex_mem_write = 1'b1;
          mem_wb_write = 1'b1;
          if_id_flush  = 1'b1;
          id_ex_flush  = 1'b1;
        end
        ld_stall: begin
          id_ex_write  = 1'b1;
          ex_mem_write = 1'b1;
          mem_wb_write = 1'b1;
          id_ex_flush  = 1'b1;
        end
        default: begin
          pc_write     = 1'b1;
          if_id_write  = 1'b1;
          id_ex_write  = 1'b1;
          ex_mem_write = 1'b1;
          mem_wb_write = 1'b1;
        end
      endcase
    end
  end

  // Stall counter saturates, flush counter wraps
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles <= 16'd0;
      flush_count  <= 16'd0;
    end else if (counters_clr) begin
      stall_cycles <= 16'd0;
      flush_count  <= 16'd0;
    end else begin
      if (!pc_write && stall_cycles != 16'hFFFF)
        stall_cycles <= stall_cycles + 16'd1;
      if (br_flush)
        flush_count <= flush_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl with WAIT_LIMIT=4.
// Output vector: {pc,ifid,idex,exmem,memwb,if_fl,id_fl,bus_err}.
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_uses_rt;
  logic        ex_memread;
  logic [4:0]  ex_rt;
  logic        ex_branch_taken;
  logic        mem_req;
  logic        mem_ready;
  logic        counters_clr;
  logic        pc_write;
  logic        if_id_write;
  logic        id_ex_write;
  logic        ex_mem_write;
  logic        mem_wb_write;
  logic        if_id_flush;
  logic        id_ex_flush;
  logic        bus_err;
  logic [15:0] stall_cycles;
  logic [15:0] flush_count;

  int n_chk  = 0;
  int n_pass = 0;

  localparam logic [7:0] OFF  = 8'h00;
  localparam logic [7:0] NORM = 8'hF8;
  localparam logic [7:0] LDU  = 8'h3A;
  localparam logic [7:0] BRF  = 8'hFE;
  localparam logic [7:0] BERR = 8'hF9;

  pipeline_ctrl #(.WAIT_LIMIT(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_uses_rt      (id_uses_rt),
    .ex_memread      (ex_memread),
    .ex_rt           (ex_rt),
    .ex_branch_taken (ex_branch_taken),
    .mem_req         (mem_req),
    .mem_ready       (mem_ready),
    .counters_clr    (counters_clr),
    .pc_write        (pc_write),
    .if_id_write     (if_id_write),
    .id_ex_write     (id_ex_write),
    .ex_mem_write    (ex_mem_write),
    .mem_wb_write    (mem_wb_write),
    .if_id_flush     (if_id_flush),
    .id_ex_flush     (id_ex_flush),
    .bus_err         (bus_err),
    .stall_cycles    (stall_cycles),
    .flush_count     (flush_count)
  );

  always #5 clk = ~clk;

  wire [7:0] outs = {pc_write, if_id_write, id_ex_write,
                     ex_mem_write, mem_wb_write,
                     if_id_flush, id_ex_flush, bus_err};

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  tag, got, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs           = 5'd0;
    id_rt           = 5'd0;
    id_uses_rt      = 1'b0;
    ex_memread      = 1'b0;
    ex_rt           = 5'd0;
    ex_branch_taken = 1'b0;
    mem_req         = 1'b0;
    mem_ready       = 1'b0;
    counters_clr    = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    #2;
    check("rst_outs", 32'(outs), 32'(OFF));
    check("rst_stall", 32'(stall_cycles), 0);
    check("rst_flush", 32'(flush_count), 0);

    cyc();
    reset = 1'b0;
    #1;
    check("first_norm", 32'(outs), 32'(NORM));

    // load-use on rs
    cyc();
    ex_memread = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
    #1 check("lu_rs", 32'(outs), 32'(LDU));
    cyc();
    idle();
    #1 check("lu_after", 32'(outs), 32'(NORM));
    check("lu_stall1", 32'(stall_cycles), 1);

    // r0 never stalls; rt only when used
    ex_memread = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
    #1 check("lu_r0", 32'(outs), 32'(NORM));
    ex_rt = 5'd5; id_rt = 5'd5; id_rs = 5'd1;
    #1 check("lu_rt_unused", 32'(outs), 32'(NORM));
    id_uses_rt = 1'b1;
    #1 check("lu_rt_used", 32'(outs), 32'(LDU));
    cyc();
    idle();
    #1 check("lu_stall2", 32'(stall_cycles), 2);

    // branch beats load-use
    ex_memread = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
    ex_branch_taken = 1'b1;
    #1 check("br_lu", 32'(outs), 32'(BRF));
    cyc();
    idle();
    #1 check("br_flushcnt", 32'(flush_count), 1);
    check("br_stall", 32'(stall_cycles), 2);

    // memory wait: 3 frozen cycles then ready
    mem_req = 1'b1; mem_ready = 1'b0;
    #1 check("mw_run", 32'(outs), 32'(OFF));
    cyc();
    #1 check("mw_w0", 32'(outs), 32'(OFF));
    cyc();
    ex_branch_taken = 1'b1;
    #1 check("mw_w1_br", 32'(outs), 32'(OFF));
    cyc();
    ex_branch_taken = 1'b0; mem_ready = 1'b1;
    #1 check("mw_ready", 32'(outs), 32'(NORM));
    cyc();
    idle();
    #1 check("mw_stall", 32'(stall_cycles), 5);
    check("mw_flushcnt", 32'(flush_count), 1);
    check("mw_idle", 32'(outs), 32'(NORM));

    // timeout: 4 frozen cycles, bus_err on 5th
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1 check($sformatf("to_frz%0d", i),
               32'(outs), 32'(OFF));
      cyc();
    end
    #1 check("to_berr", 32'(outs), 32'(BERR));
    cyc();
    idle();
    #1 check("to_run", 32'(outs), 32'(NORM));
    check("to_stall", 32'(stall_cycles), 9);

    // clear overrides a stall increment
    ex_memread = 1'b1; ex_rt = 5'd3; id_rs = 5'd3;
    counters_clr = 1'b1;
    cyc();
    idle();
    #1 check("clr_stall", 32'(stall_cycles), 0);
    check("clr_flush", 32'(flush_count), 0);

    // build counts, then reset during MEM_WAIT
    ex_branch_taken = 1'b1;
    cyc();
    idle();
    mem_req = 1'b1; mem_ready = 1'b0;
    cyc();
    cyc();
    #1 check("pre_rst_stall", 32'(stall_cycles), 2);
    reset = 1'b1;
    #1 check("mwrst_outs", 32'(outs), 32'(OFF));
    check("mwrst_stall", 32'(stall_cycles), 0);
    check("mwrst_flush", 32'(flush_count), 0);
    cyc();
    idle();
    reset = 1'b0;
    #1 check("mwrst_norm", 32'(outs), 32'(NORM));
    for (int i = 0; i < 4; i++) begin
      cyc();
      #1 check($sformatf("mwrst_nob%0d", i),
               32'(outs), 32'(NORM));
    end
    mem_req = 1'b1; mem_ready = 1'b1;
    #1 check("mwrst_runrdy", 32'(outs), 32'(NORM));
    cyc();
    idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
